// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO sequencer: op encodings, FSM states, divide-by-zero constant.
// Optional multiply-accumulate ops are enabled by defining HILO_MACC_EN (Op widens to 4 bits).
package hilo_pkg;

`ifdef HILO_MACC_EN
  localparam int OP_W = 4;
  typedef enum logic [OP_W-1:0] {
    MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO,
    MADD, MADDU, MSUB, MSUBU
  } hilo_op_t;
`else
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO
  } hilo_op_t;
`endif

  typedef enum logic [1:0] {
    IDLE, MUL_WAIT, DIV_RUN, DIV_FIX
  } hilo_state_t;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic [31:0] cneg(input logic [31:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return cneg(v, v[31]);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider core: load, then one quotient bit per step; W steps per divide.
// No backpressure: the owner pulses load once and asserts step for exactly W cycles.
module div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic [W-1:0] dvs;
  logic [W:0]   shifted;
  logic [W:0]   diff;

  // Top bit of diff is the borrow: set when the trial subtraction fails.
  always_comb begin
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (step) begin
      if (!diff[W]) begin
        rem <= diff[W-1:0];
        quo <= {quo[W-2:0], 1'b1};
      end else begin
        rem <= shifted[W-1:0];
        quo <= {quo[W-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/hilo_sequencer.sv
// HI/LO owner for EX: MUL busy MUL_LAT cycles, DIV busy DIV_ITER+1, MT*/MF* single-cycle.
// Stall = Start & Busy; EX holds the op until it is accepted. HILO_MACC_EN adds MADD/MSUB.
module hilo_sequencer
  import hilo_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            Start,
  input  logic [OP_W-1:0] Op,
  input  logic [31:0]     A,
  input  logic [31:0]     B,
  input  logic [63:0]     MULout,
  output logic [31:0]     MulA,
  output logic [31:0]     MulB,
  output logic            MulSign,
  output logic [31:0]     Out,
  output logic            OutValid,
  output logic            Stall,
  output logic            Busy,
  output logic [31:0]     HI,
  output logic [31:0]     LO
);

  localparam int CNT_MAX = (MUL_LAT > DIV_ITER) ? MUL_LAT : DIV_ITER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  hilo_state_t      state, state_nxt;
  hilo_op_t         op;
  logic [CNT_W-1:0] cnt;

  logic acc_mul, acc_div, wr_hi, wr_lo, rd;
  logic mul_done, div_step, div_done;

  logic [31:0] a_sav;
  logic        div_zero, neg_q, neg_r;
  logic [31:0] quo, rem;
  logic [31:0] dvd_in, dvs_in;
  logic [63:0] mul_res;

`ifdef HILO_MACC_EN
  logic macc_add, macc_sub;
`endif

  always_comb begin
    op        = hilo_op_t'(Op);
    state_nxt = state;
    acc_mul   = 1'b0;
    acc_div   = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    rd        = 1'b0;
    mul_done  = 1'b0;
    div_step  = 1'b0;
    div_done  = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          case (op)
            MULT, MULTU: begin
              acc_mul   = 1'b1;
              state_nxt = MUL_WAIT;
            end
`ifdef HILO_MACC_EN
            MADD, MADDU, MSUB, MSUBU: begin
              acc_mul   = 1'b1;
              state_nxt = MUL_WAIT;
            end
`endif
            DIV, DIVU: begin
              acc_div   = 1'b1;
              state_nxt = DIV_RUN;
            end
            MTHI:       wr_hi = 1'b1;
            MTLO:       wr_lo = 1'b1;
            MFHI, MFLO: rd    = 1'b1;
            default:    ;
          endcase
        end
      end
      MUL_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          mul_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      DIV_RUN: begin
        div_step = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = DIV_FIX;
      end
      DIV_FIX: begin
        div_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy     = (state != IDLE);
  assign Stall    = Start & Busy;
  assign OutValid = rd;
  assign Out      = rd ? ((op == MFHI) ? HI : LO) : 32'h0;

  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (acc_mul) begin
      cnt <= CNT_W'(MUL_LAT);
    end else if (acc_div) begin
      cnt <= CNT_W'(DIV_ITER);
    end else if (state == MUL_WAIT || state == DIV_RUN) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // The core only sees magnitudes; signs are restored in DIV_FIX.
  assign dvd_in = (op == DIV) ? abs32(A) : A;
  assign dvs_in = (op == DIV) ? abs32(B) : B;

  div_iter #(.W(32)) u_div (
    .clk       (clk),
    .nrst      (nrst),
    .load      (acc_div),
    .step      (div_step),
    .dividend  (dvd_in),
    .divisor   (dvs_in),
    .quotient  (quo),
    .remainder (rem)
  );

`ifdef HILO_MACC_EN
  assign mul_res = macc_sub ? ({HI, LO} - MULout) :
                   macc_add ? ({HI, LO} + MULout) : MULout;
`else
  assign mul_res = MULout;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      HI       <= '0;
      LO       <= '0;
      MulA     <= '0;
      MulB     <= '0;
      MulSign  <= 1'b0;
      a_sav    <= '0;
      div_zero <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`ifdef HILO_MACC_EN
      macc_add <= 1'b0;
      macc_sub <= 1'b0;
`endif
    end else begin
      if (acc_mul) begin
        MulA <= A;
        MulB <= B;
`ifdef HILO_MACC_EN
        MulSign  <= (op == MULT) || (op == MADD) || (op == MSUB);
        macc_add <= (op == MADD) || (op == MADDU);
        macc_sub <= (op == MSUB) || (op == MSUBU);
`else
        MulSign <= (op == MULT);
`endif
      end
      if (acc_div) begin
        a_sav    <= A;
        div_zero <= (B == 32'h0);
        neg_q    <= (op == DIV) && (A[31] ^ B[31]);
        neg_r    <= (op == DIV) && A[31];
      end
      if (wr_hi) HI <= A;
      if (wr_lo) LO <= A;
      if (mul_done) {HI, LO} <= mul_res;
      // 0x8000_0000 / -1 falls out naturally: |q| = 0x8000_0000 negates to itself.
      if (div_done) begin
        if (div_zero) begin
          LO <= DIV0_LO;
          HI <= a_sav;
        end else begin
          LO <= cneg(quo, neg_q);
          HI <= cneg(rem, neg_r);
        end
      end
    end
  end

endmodule

// File: tb/tb_hilo_sequencer.sv
// Bench for hilo_sequencer: directed cases plus random ops against an arithmetic HI/LO model.
module tb_hilo_sequencer;
  import hilo_pkg::*;

  localparam int MUL_LAT  = 2;
  localparam int DIV_ITER = 32;

  logic            clk = 1'b0;
  logic            nrst;
  logic            Start;
  logic [OP_W-1:0] Op;
  logic [31:0]     A, B;
  logic [63:0]     MULout = '0;
  logic [31:0]     MulA, MulB, Out, HI, LO;
  logic            MulSign, OutValid, Stall, Busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  hilo_sequencer #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
    .clk(clk), .nrst(nrst), .Start(Start), .Op(Op), .A(A), .B(B), .MULout(MULout),
    .MulA(MulA), .MulB(MulB), .MulSign(MulSign), .Out(Out), .OutValid(OutValid),
    .Stall(Stall), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Shared MUL unit: one register stage, so product is ready MUL_LAT=2 edges after MulA/MulB.
  always @(posedge clk) begin
    if (MulSign) MULout <= {{32{MulA[31]}}, MulA} * {{32{MulB[31]}}, MulB};
    else         MULout <= {32'h0, MulA} * {32'h0, MulB};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    case (op)
      MULT:  begin sp = longint'(int'(a)) * longint'(int'(b)); {m_hi, m_lo} = sp; end
      MULTU: begin up = {32'h0, a} * {32'h0, b}; {m_hi, m_lo} = up; end
      DIVU: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      DIV: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
        else begin sa = int'(a); sb = int'(b); m_lo = sa / sb; m_hi = sa % sb; end
      end
      MTHI: m_hi = a;
      MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int exp_busy(input hilo_op_t op);
    if (op == MULT || op == MULTU) return MUL_LAT;
    if (op == DIV || op == DIVU)   return DIV_ITER + 1;
    return 0;
  endfunction

  // Called just after a posedge; returns just after a posedge with Start low.
  task automatic run_op(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n;
    int bc;
    Start = 1'b1; Op = op; A = a; B = b;
    n = 0;
    @(negedge clk);
    while (Stall && n < 200) begin
      n++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    if (n >= 200) check({tag, "_accept_timeout"}, 1, 0);
    if (op == MFHI || op == MFLO) begin
      check({tag, "_ov"}, OutValid, 1);
      check({tag, "_out"}, Out, (op == MFHI) ? m_hi : m_lo);
    end
    @(posedge clk); #1;
    Start = 1'b0;
    model_apply(op, a, b);
    bc = 0;
    @(negedge clk);
    while (Busy && bc < 200) begin
      bc++;
      @(negedge clk);
    end
    check({tag, "_busy"}, bc, exp_busy(op));
    check({tag, "_hi"}, HI, m_hi);
    check({tag, "_lo"}, LO, m_lo);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    hilo_op_t rop;
    nrst = 1'b0; Start = 1'b0; Op = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", Busy, 0);
    check("rst_stall", Stall, 0);
    check("rst_ov", OutValid, 0);
    check("rst_out", Out, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_mula", MulA, 0);
    check("rst_mulb", MulB, 0);
    check("rst_mulsign", MulSign, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;

    run_op(MULT, 32'hFFFF_FFFD, 32'd7, "mult_m3x7");
    check("mult_m3x7_hi_k", HI, 32'hFFFF_FFFF);
    check("mult_m3x7_lo_k", LO, 32'hFFFF_FFEB);
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(DIVU, 32'd100, 32'd7, "divu_100_7");
    check("divu_lo_k", LO, 32'd14);
    check("divu_hi_k", HI, 32'd2);
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    check("div_m7_lo_k", LO, 32'hFFFF_FFFD);
    check("div_m7_hi_k", HI, 32'hFFFF_FFFF);
    run_op(DIV, 32'd5, 32'd0, "div_by0");
    check("div_by0_lo_k", LO, 32'hFFFF_FFFF);
    check("div_by0_hi_k", HI, 32'd5);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_lo_k", LO, 32'h8000_0000);
    check("div_ovf_hi_k", HI, 32'h0);

    // MFLO presented the cycle after MULT is accepted.
    Start = 1'b1; Op = MULT; A = 32'd1234; B = 32'hFFFF_0000;
    @(negedge clk);
    check("mf_after_mult_accept", Stall, 0);
    @(posedge clk); #1;
    Op = MFLO;
    model_apply(MULT, 32'd1234, 32'hFFFF_0000);
    n = 0;
    @(negedge clk);
    while (Stall && n < 50) begin
      n++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    check("mf_after_mult_stalls", n, MUL_LAT);
    check("mf_after_mult_ov", OutValid, 1);
    check("mf_after_mult_out", Out, m_lo);
    @(posedge clk); #1;
    Start = 1'b0;
    @(posedge clk); #1;

    // MTHI followed immediately by MFHI: no stall, new value visible.
    Start = 1'b1; Op = MTHI; A = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mthi_stall", Stall, 0);
    @(posedge clk); #1;
    Op = MFHI;
    model_apply(MTHI, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    check("mfhi_stall", Stall, 0);
    check("mfhi_ov", OutValid, 1);
    check("mfhi_out", Out, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    Start = 1'b0;
    @(posedge clk); #1;

    // Reset during DIV_RUN cycle 10 aborts the divide.
    Start = 1'b1; Op = DIV; A = 32'd1000; B = 32'd3;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    check("midrst_busy", Busy, 0);
    check("midrst_hi", HI, 0);
    check("midrst_lo", LO, 0);
    @(posedge clk); #1;
    run_op(MFLO, 32'h0, 32'h0, "midrst_mflo");

    for (int i = 0; i < 40; i++) begin
      rop = hilo_op_t'($urandom_range(0, 7));
      run_op(rop, rand_operand(), rand_operand(), $sformatf("rnd%0d_%s", i, rop.name()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
